// File: rtl/pwm_seq_ctrl.sv
// Segment sequencer for one pwm_pulse channel: steps through a table of
// (width, gap, times) segments, loading each into the channel and arming it.
module pwm_seq_ctrl #(
    parameter int _RAM_WIDTH = 32,
    parameter int SEG_DEPTH  = 8,
    parameter int SEG_AW     = 3,
    parameter int GAP_CYC    = 2
) (
    input  logic                  io_clk,
    input  logic                  io_rst_n,
    input  logic                  cfg_we,
    input  logic [SEG_AW-1:0]     cfg_addr,
    input  logic [_RAM_WIDTH-1:0] cfg_width,
    input  logic [_RAM_WIDTH-1:0] cfg_gap,
    input  logic [_RAM_WIDTH-1:0] cfg_times,
    input  logic [SEG_AW:0]       seq_len,
    input  logic                  seq_loop,
    input  logic                  seq_start,
    input  logic                  seq_stop,
    output logic                  pwm_en,
    output logic [_RAM_WIDTH-1:0] pwm_width,
    output logic [_RAM_WIDTH-1:0] pwm_gap,
    output logic [_RAM_WIDTH-1:0] pwm_times,
    input  logic                  pwm_valid,
    input  logic                  pwm_busy,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  seq_err,
    output logic [SEG_AW-1:0]     cur_seg
);

    typedef enum logic [2:0] {
        IDLE, LOAD, ARM, RUN, GAP, STOP
    } state_t;

    localparam logic [SEG_AW:0] DEPTH_L    = SEG_DEPTH[SEG_AW:0];
    localparam logic [15:0]     GAP_RELOAD = 16'(GAP_CYC - 3);

    logic [_RAM_WIDTH-1:0] tbl_w [SEG_DEPTH];
    logic [_RAM_WIDTH-1:0] tbl_g [SEG_DEPTH];
    logic [_RAM_WIDTH-1:0] tbl_t [SEG_DEPTH];

    state_t          state;
    logic [SEG_AW-1:0] seg;
    logic [SEG_AW:0]   len_q;
    logic              loop_q;
    logic [15:0]       gap_cnt;
    logic              len_ok;
    logic              last_seg;

    assign len_ok   = (seq_len != '0) && (seq_len <= DEPTH_L);
    assign last_seg = ({1'b0, seg} == (len_q - 1'b1));
    assign seq_busy = (state != IDLE);

    always_ff @(posedge io_clk) begin
        if (cfg_we) begin
            tbl_w[cfg_addr] <= cfg_width;
            tbl_g[cfg_addr] <= cfg_gap;
            tbl_t[cfg_addr] <= cfg_times;
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state     <= IDLE;
            seg       <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            gap_cnt   <= '0;
            pwm_en    <= 1'b0;
            pwm_width <= '0;
            pwm_gap   <= '0;
            pwm_times <= '0;
            seq_done  <= 1'b0;
            seq_err   <= 1'b0;
            cur_seg   <= '0;
        end else begin
            seq_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (seq_start && !seq_stop) begin
                        if (len_ok) begin
                            seq_err <= 1'b0;
                            seg     <= '0;
                            len_q   <= seq_len;
                            loop_q  <= seq_loop;
                            state   <= LOAD;
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (seq_stop) begin
                        seq_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        pwm_width <= tbl_w[seg];
                        pwm_gap   <= tbl_g[seg];
                        pwm_times <= tbl_t[seg];
                        cur_seg   <= seg;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (seq_stop) begin
                        seq_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        pwm_en <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (seq_stop) begin
                        pwm_en <= 1'b0;
                        if (pwm_valid) begin
                            seq_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= STOP;
                        end
                    end else if (pwm_valid) begin
                        pwm_en <= 1'b0;
                        if (last_seg && !loop_q) begin
                            seq_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            seg <= last_seg ? '0 : seg + 1'b1;
                            // LOAD and ARM already supply two of the low cycles
                            if (GAP_CYC > 2) begin
                                gap_cnt <= GAP_RELOAD;
                                state   <= GAP;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                GAP: begin
                    if (seq_stop) begin
                        seq_done <= 1'b1;
                        state    <= IDLE;
                    end else if (gap_cnt == '0) begin
                        state <= LOAD;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (pwm_valid || !pwm_busy) begin
                        seq_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Directed bench for pwm_seq_ctrl; the bench plays the pwm_pulse channel
// by driving pwm_valid/pwm_busy by hand.
module tb_pwm_seq_ctrl;

    logic        io_clk = 1'b0;
    logic        io_rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_width = '0;
    logic [31:0] cfg_gap = '0;
    logic [31:0] cfg_times = '0;
    logic [3:0]  seq_len = '0;
    logic        seq_loop = 1'b0;
    logic        seq_start = 1'b0;
    logic        seq_stop = 1'b0;
    logic        pwm_en;
    logic [31:0] pwm_width;
    logic [31:0] pwm_gap;
    logic [31:0] pwm_times;
    logic        pwm_valid = 1'b0;
    logic        pwm_busy = 1'b0;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_err;
    logic [2:0]  cur_seg;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_seq_ctrl dut (
        .io_clk    (io_clk),
        .io_rst_n  (io_rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_times (cfg_times),
        .seq_len   (seq_len),
        .seq_loop  (seq_loop),
        .seq_start (seq_start),
        .seq_stop  (seq_stop),
        .pwm_en    (pwm_en),
        .pwm_width (pwm_width),
        .pwm_gap   (pwm_gap),
        .pwm_times (pwm_times),
        .pwm_valid (pwm_valid),
        .pwm_busy  (pwm_busy),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .seq_err   (seq_err),
        .cur_seg   (cur_seg)
    );

    always #5 io_clk = ~io_clk;

    typedef struct {
        logic       st, sp, vl, pb;
        logic [3:0] len;
        logic       lp;
        logic       en, sb, dn, er;
        logic [2:0] sg;
        logic [31:0] w;
    } vec_t;

    localparam int NV = 38;
    vec_t v [NV];

    function automatic vec_t mk(
        input logic st, sp, vl, pb, input int len, input logic lp,
        input logic en, sb, dn, er, input int sg, input int w);
        vec_t r;
        r.st = st; r.sp = sp; r.vl = vl; r.pb = pb;
        r.len = 4'(len); r.lp = lp;
        r.en = en; r.sb = sb; r.dn = dn; r.er = er;
        r.sg = 3'(sg); r.w = 32'(w);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, sp, vl, pb);
        seq_start = st;
        seq_stop  = sp;
        pwm_valid = vl;
        pwm_busy  = pb;
        @(posedge io_clk);
        #1;
        seq_start = 1'b0;
        seq_stop  = 1'b0;
        pwm_valid = 1'b0;
    endtask

    task automatic wr(input int a, input int w, input int g, input int t);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(a);
        cfg_width = 32'(w);
        cfg_gap   = 32'(g);
        cfg_times = 32'(t);
        step(1'b0, 1'b0, 1'b0, pwm_busy);
        cfg_we = 1'b0;
    endtask

    task automatic wait_en(input string nm);
        int n = 0;
        while (!pwm_en && n < 10) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        if (!pwm_en) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: pwm_en timeout got 0 want 1", nm);
        end
    endtask

    initial begin
        int low;
        int dcnt;
        logic [31:0] expw [3];

        v[0]  = mk(1,0,0,0,1,0, 0,1,0,0,0,0);
        v[1]  = mk(0,0,0,0,1,0, 0,1,0,0,0,4);
        v[2]  = mk(0,0,0,0,1,0, 1,1,0,0,0,4);
        v[3]  = mk(0,0,0,1,1,0, 1,1,0,0,0,4);
        v[4]  = mk(0,0,1,1,1,0, 0,0,1,0,0,4);
        v[5]  = mk(0,0,0,0,1,0, 0,0,0,0,0,4);
        v[6]  = mk(1,0,0,0,0,0, 0,0,0,1,0,4);
        v[7]  = mk(1,0,0,0,9,0, 0,0,0,1,0,4);
        v[8]  = mk(0,0,0,0,9,0, 0,0,0,1,0,4);
        v[9]  = mk(1,0,0,0,2,1, 0,1,0,0,0,4);
        v[10] = mk(0,0,0,0,2,1, 0,1,0,0,0,4);
        v[11] = mk(0,0,0,1,2,1, 1,1,0,0,0,4);
        v[12] = mk(0,0,1,1,2,1, 0,1,0,0,0,4);
        v[13] = mk(0,0,0,0,2,1, 0,1,0,0,1,5);
        v[14] = mk(0,0,0,0,2,1, 1,1,0,0,1,5);
        v[15] = mk(0,0,1,1,2,1, 0,1,0,0,1,5);
        v[16] = mk(0,0,0,0,2,1, 0,1,0,0,0,4);
        v[17] = mk(0,0,0,1,2,1, 1,1,0,0,0,4);
        v[18] = mk(0,1,0,1,2,1, 0,1,0,0,0,4);
        v[19] = mk(0,0,0,1,2,1, 0,1,0,0,0,4);
        v[20] = mk(0,0,1,1,2,1, 0,0,1,0,0,4);
        v[21] = mk(0,0,0,0,2,0, 0,0,0,0,0,4);
        v[22] = mk(1,1,0,0,1,0, 0,0,0,0,0,4);
        v[23] = mk(1,0,0,0,3,0, 0,1,0,0,0,4);
        v[24] = mk(0,1,0,0,3,0, 0,0,1,0,0,4);
        v[25] = mk(0,0,0,0,3,0, 0,0,0,0,0,4);
        v[26] = mk(1,0,0,0,3,0, 0,1,0,0,0,4);
        v[27] = mk(0,0,0,0,3,0, 0,1,0,0,0,4);
        v[28] = mk(0,0,0,1,3,0, 1,1,0,0,0,4);
        v[29] = mk(1,0,0,1,3,0, 1,1,0,0,0,4);
        v[30] = mk(0,1,1,1,3,0, 0,0,1,0,0,4);
        v[31] = mk(0,0,0,0,3,0, 0,0,0,0,0,4);
        v[32] = mk(1,0,0,0,1,0, 0,1,0,0,0,4);
        v[33] = mk(0,0,0,0,1,0, 0,1,0,0,0,4);
        v[34] = mk(0,0,0,0,1,0, 1,1,0,0,0,4);
        v[35] = mk(0,1,0,0,1,0, 0,1,0,0,0,4);
        v[36] = mk(0,0,0,0,1,0, 0,0,1,0,0,4);
        v[37] = mk(0,0,0,0,1,0, 0,0,0,0,0,4);

        // reset
        #2 io_rst_n = 1'b0;
        repeat (2) @(posedge io_clk);
        #1;
        check("rst pwm_en", 32'(pwm_en), 0);
        check("rst seq_busy", 32'(seq_busy), 0);
        check("rst seq_done", 32'(seq_done), 0);
        check("rst seq_err", 32'(seq_err), 0);
        check("rst cur_seg", 32'(cur_seg), 0);
        check("rst pwm_width", pwm_width, 0);
        io_rst_n = 1'b1;

        wr(0, 4, 3, 2);
        wr(1, 5, 1, 3);
        wr(2, 1, 4, 2);

        for (int i = 0; i < NV; i++) begin
            seq_len  = v[i].len;
            seq_loop = v[i].lp;
            step(v[i].st, v[i].sp, v[i].vl, v[i].pb);
            check($sformatf("vec%0d pwm_en", i), 32'(pwm_en), 32'(v[i].en));
            check($sformatf("vec%0d seq_busy", i), 32'(seq_busy), 32'(v[i].sb));
            check($sformatf("vec%0d seq_done", i), 32'(seq_done), 32'(v[i].dn));
            check($sformatf("vec%0d seq_err", i), 32'(seq_err), 32'(v[i].er));
            check($sformatf("vec%0d cur_seg", i), 32'(cur_seg), 32'(v[i].sg));
            check($sformatf("vec%0d pwm_width", i), pwm_width, v[i].w);
        end
        check("t1 pwm_gap", pwm_gap, 3);
        check("t1 pwm_times", pwm_times, 2);

        // three segments, exact gap between them
        wr(0, 2, 2, 1);
        expw[0] = 2; expw[1] = 5; expw[2] = 1;
        seq_len = 4'd3;
        seq_loop = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        low = 0;
        for (int k = 0; k < 3; k++) begin
            while (!pwm_en && low < 10) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                if (!pwm_en) low++;
            end
            if (k > 0) check($sformatf("t2 gap%0d low cycles", k), 32'(low), 2);
            check($sformatf("t2 seg%0d pwm_en", k), 32'(pwm_en), 1);
            check($sformatf("t2 seg%0d cur_seg", k), 32'(cur_seg), 32'(k));
            check($sformatf("t2 seg%0d pwm_width", k), pwm_width, expw[k]);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check($sformatf("t2 seg%0d hold", k), 32'(pwm_en), 1);
            step(1'b0, 1'b0, 1'b1, 1'b1);
            low = pwm_en ? 0 : 1;
        end
        check("t2 seq_done", 32'(seq_done), 1);
        check("t2 seq_busy", 32'(seq_busy), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2 done width", 32'(seq_done), 0);

        // continuous segment ends only via stop
        wr(0, 3, 3, 0);
        seq_len = 4'd1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        wait_en("t4");
        check("t4 pwm_times", pwm_times, 0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            if (seq_done) dcnt++;
        end
        check("t4 no done", 32'(dcnt), 0);
        check("t4 still en", 32'(pwm_en), 1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("t4 stop en", 32'(pwm_en), 0);
        check("t4 stop busy", 32'(seq_busy), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4 done", 32'(seq_done), 1);
        check("t4 idle", 32'(seq_busy), 0);

        // rewrite during RUN, then async reset mid-run
        step(1'b1, 1'b0, 1'b0, 1'b0);
        wait_en("t6");
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_width = 32'd9;
        cfg_gap = 32'd3;
        cfg_times = 32'd0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cfg_we = 1'b0;
        check("t6 running width", pwm_width, 3);
        check("t6 running en", 32'(pwm_en), 1);
        #2 io_rst_n = 1'b0;
        #1;
        check("t6 rst en", 32'(pwm_en), 0);
        check("t6 rst busy", 32'(seq_busy), 0);
        check("t6 rst done", 32'(seq_done), 0);
        @(posedge io_clk);
        #1 io_rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6 next pass width", pwm_width, 9);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t6 next pass en", 32'(pwm_en), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6 final done", 32'(seq_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
